// File: rtl/scene_cfg_loader.sv
// UART-fed scene configuration loader: parses write packets into a shadow register
// file and commits it to the active file on frame_tick. Optional macro: SCENE_CFG_CKSUM_EN.
module scene_cfg_loader #(
    parameter int NUM_REGS = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  frame_tick,
    output logic [NUM_REGS*8-1:0] cfg_out,
    output logic                  cfg_commit,
    output logic                  busy,
    output logic [7:0]            err_count
);
    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef SCENE_CFG_CKSUM_EN
    localparam logic [7:0] CKSUM_KEY = 8'h5A;

    function automatic logic [7:0] pkt_cksum(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data ^ CKSUM_KEY;
    endfunction

    typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA} state_t;
`else
    typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_ADDR} state_t;
`endif

    function automatic logic addr_in_range(input logic [7:0] addr);
        return (addr < 8'(NUM_REGS));
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [7:0]         addr_r;
    logic [7:0]         addr_nxt_s;
    logic [7:0]         wr_data_s;
    logic               accept_s;
    logic               reject_s;
    logic               timeout_s;
    logic               commit_s;
    logic               dirty_r;
    logic               busy_r;
    logic               commit_r;
    logic [7:0]         err_r;
    logic [CNT_W-1:0]   tmo_cnt_r;
    logic [7:0]         shadow_r [NUM_REGS];
    logic [7:0]         active_r [NUM_REGS];
`ifdef SCENE_CFG_CKSUM_EN
    logic [7:0]         data_r;
    logic [7:0]         data_nxt_s;
`endif

    assign timeout_s = (state_r != IDLE) && (tmo_cnt_r == CNT_W'(TIMEOUT));
    assign commit_s  = frame_tick && dirty_r;

    // Packet parser next-state; an expiring timeout forces the byte to be seen from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
`ifdef SCENE_CFG_CKSUM_EN
        data_nxt_s  = data_r;
        wr_data_s   = data_r;
`else
        wr_data_s   = rx_data;
`endif
        if (timeout_s) begin
            if (rx_done && (rx_data == SYNC_BYTE)) begin
                state_nxt_s = GOT_SYNC;
            end else begin
                state_nxt_s = IDLE;
            end
        end else if (rx_done) begin
            case (state_r)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_nxt_s = GOT_SYNC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                GOT_SYNC: begin
                    addr_nxt_s  = rx_data;
                    state_nxt_s = GOT_ADDR;
                end
`ifdef SCENE_CFG_CKSUM_EN
                GOT_ADDR: begin
                    data_nxt_s  = rx_data;
                    state_nxt_s = GOT_DATA;
                end
                GOT_DATA: begin
                    state_nxt_s = IDLE;
                    if ((rx_data == pkt_cksum(addr_r, data_r)) && addr_in_range(addr_r)) begin
                        accept_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end
`else
                GOT_ADDR: begin
                    state_nxt_s = IDLE;
                    if (addr_in_range(addr_r)) begin
                        accept_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end
`endif
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Parser state, inter-byte timeout counter, error counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= 8'h00;
`ifdef SCENE_CFG_CKSUM_EN
            data_r    <= 8'h00;
`endif
            tmo_cnt_r <= '0;
            err_r     <= 8'h00;
            busy_r    <= 1'b0;
            commit_r  <= 1'b0;
            dirty_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            addr_r    <= addr_nxt_s;
`ifdef SCENE_CFG_CKSUM_EN
            data_r    <= data_nxt_s;
`endif
            if (rx_done || timeout_s || (state_r == IDLE)) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end
            if ((reject_s || timeout_s) && (err_r != 8'hFF)) begin
                err_r <= err_r + 8'h01;
            end
            busy_r   <= (state_nxt_s != IDLE);
            commit_r <= commit_s;
            // A write landing with a commit stays dirty for the next frame.
            if (accept_s) begin
                dirty_r <= 1'b1;
            end else if (commit_s) begin
                dirty_r <= 1'b0;
            end
        end
    end

    // Shadow and active register files; commit copies the pre-write shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= 8'h00;
                active_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (accept_s && (addr_r == 8'(i))) begin
                    shadow_r[i] <= wr_data_s;
                end
                if (commit_s) begin
                    active_r[i] <= shadow_r[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg_out
        assign cfg_out[gi*8 +: 8] = active_r[gi];
    end

    assign cfg_commit = commit_r;
    assign busy       = busy_r;
    assign err_count  = err_r;

endmodule

// File: doc/scene_cfg_loader.md
# scene_cfg_loader

UART-fed configuration controller for the rasterizer pipeline. Parses framed write packets from the UART receiver into a shadow register file. At each frame boundary it commits dirty shadow contents to the active register file that drives the vertex stage (`vs`), so scene parameters never change mid-frame. Sits between the UART RX unit and `vs`, gated by a frame tick derived from the VGA timing block.

## Interface
Parameters:
- `NUM_REGS`, 8 — number of 8-bit config registers; must be ≤ 16.
- `TIMEOUT`, 65535 — clk cycles allowed between bytes of one packet before abort.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `rx_data`  in  8  received byte; valid only when `rx_done`=1
- `rx_done`  in  1  single-cycle byte-received strobe
- `frame_tick`  in  1  single-cycle pulse at start of vertical blank
- `cfg_out`  out  NUM_REGS*8  active registers, reg i at bits [8i+7:8i]
- `cfg_commit`  out  1  one-cycle pulse when `cfg_out` was updated
- `busy`  out  1  high while a packet is partially received
- `err_count`  out  8  saturating count of rejected packets

## Operation
- Packet format: `0xA5`, `ADDR`, `DATA`, `CKSUM`.
- `CKSUM` = `ADDR ^ DATA ^ 0x5A`.
- FSM states: IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA.
  - IDLE: `0xA5` → GOT_SYNC; any other byte ignored, no error.
  - GOT_SYNC: latch ADDR → GOT_ADDR.
  - GOT_ADDR: latch DATA → GOT_DATA.
  - GOT_DATA: on CKSUM byte → IDLE; packet accepted or rejected as below.
- Accept: checksum matches and ADDR < NUM_REGS → shadow[ADDR] ← DATA; set dirty.
- Reject: bad checksum or ADDR ≥ NUM_REGS → shadow unchanged; `err_count` +1, saturating at 255.
- Timeout: a cycle counter is cleared on every `rx_done`. In any state other than IDLE, reaching TIMEOUT → IDLE and `err_count` +1.
- `busy` = (state ≠ IDLE).
- Commit: `frame_tick` with dirty=1 → active ← shadow, dirty cleared, `cfg_commit` pulses.
- `frame_tick` with dirty=0 → no action, no pulse.
- Repeated writes to one address within a frame: last write wins.

## Timing
- Reset values: all outputs 0, shadow 0, dirty 0, state IDLE, timeout counter 0.
- Reset asserted mid-packet discards the partial packet with no error count.
- Shadow write completes the cycle after the final byte's `rx_done`.
- Commit latency: `cfg_out` changes and `cfg_commit` is high in the cycle after `frame_tick`.
- Accepted write completing in the same cycle as a commit:
  - the commit copies the pre-write shadow;
  - the new write lands in shadow and sets dirty;
  - it appears at the next `frame_tick`.
- `rx_done` in the same cycle as timeout expiry: the timeout wins. The byte is re-evaluated in IDLE, so `0xA5` starts a new packet.
- Throughput: one byte per cycle sustained; no backpressure.

## Configuration
- `SCENE_CFG_CKSUM_EN`
  - Defined: 4-byte packets with checksum check as above.
  - Undefined: 3-byte packets (`0xA5`, ADDR, DATA). GOT_DATA state is removed and DATA completes the packet. Only an out-of-range ADDR or a timeout increments `err_count`.

## Test plan
- Packet A5 02 3C 64, then `frame_tick` → `cfg_out[23:16]`=0x3C one cycle after the tick; `cfg_commit` pulses once; `err_count`=0.
- Packet A5 02 3C 00 (bad cksum), then `frame_tick` → `cfg_out` unchanged; no `cfg_commit`; `err_count`=1.
- Packet A5 09 11 xx with NUM_REGS=8 and a valid cksum → rejected; `err_count`=1.
- A5 01, then 70000 idle cycles → `busy` drops at TIMEOUT; `err_count`=1; following A5 01 77 2C commits reg1=0x77.
- Final byte of A5 00 FF A5 arrives in the same cycle as `frame_tick` → first commit leaves reg0=0; next `frame_tick` gives reg0=0xFF.
- Reset asserted after A5 03 → `busy`=0; `cfg_out`=0; `err_count`=0; next full packet accepted normally.
